// File: rtl/interrupt_seq.sv
// interrupt_seq: 6502-style RES/NMI/IRQ/BRK interrupt sequencer driving push and vector-fetch cycles
module interrupt_seq (
  input  logic       PHI0,
  input  logic       RES,
  input  logic       n_NMIP,
  input  logic       n_IRQP,
  input  logic       RESP,
  input  logic       n_PRDY,
  input  logic       I_FLAG,
  input  logic       FETCH,
  input  logic       BRK_OP,
  output logic [2:0] STEP,
  output logic       DORES,
  output logic       PUSH_EN,
  output logic       WR_SUPPRESS,
  output logic       B_OUT,
  output logic [2:0] VADDR,
  output logic       VEC_EN,
  output logic       SET_I,
  output logic       SEQ_BUSY
);
  typedef enum logic [2:0] {IDLE, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI} step_t;
  typedef enum logic [1:0] {SRC_RES, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;
  step_t step, step_n;
  src_t  src, src_n;
  logic  nmi_prev, nmi_pend, nmi_pend_n, res_pend, res_pend_n, vlo_seen;
  logic  nmi_edge, irq_act, start, stall, leave_vlo, leave_vhi;
  // State register; vlo_seen remembers VEC_LO so SET_I fires once per entry
  always_ff @(posedge PHI0 or posedge RES)
    if (RES) begin
      step     <= IDLE;
      src      <= SRC_RES;
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
      res_pend <= 1'b1;
      vlo_seen <= 1'b0;
    end else begin
      step     <= step_n;
      src      <= src_n;
      nmi_prev <= ~n_NMIP;
      nmi_pend <= nmi_pend_n;
      res_pend <= res_pend_n;
      vlo_seen <= step == VEC_LO;
    end
  // Next-state: start/advance/stall, source latch with NMI hijack, pending flags
  always_comb begin
    nmi_edge   = ~n_NMIP & ~nmi_prev;
    irq_act    = ~n_IRQP & ~I_FLAG;
    stall      = n_PRDY & (step == DUMMY || step == VEC_LO || step == VEC_HI);
    start      = step == IDLE && ~n_PRDY && ~RESP && (res_pend || (FETCH && (nmi_pend || irq_act || BRK_OP)));
    leave_vlo  = step == VEC_LO && ~n_PRDY && ~RESP;
    leave_vhi  = step == VEC_HI && ~n_PRDY && ~RESP;
    step_n     = RESP ? IDLE :
                 start ? DUMMY :
                 (step == IDLE || stall) ? step :
                 step == VEC_HI ? IDLE : step_t'(step + 3'd1);
    src_n      = start ? (res_pend ? SRC_RES : nmi_pend ? SRC_NMI : irq_act ? SRC_IRQ : SRC_BRK) :
                 (step == PUSH_P && nmi_pend && (src == SRC_IRQ || src == SRC_BRK)) ? SRC_NMI : src;
    nmi_pend_n = nmi_edge | (nmi_pend & ~(leave_vlo & src == SRC_NMI));
    res_pend_n = RESP | (res_pend & ~(leave_vhi & src == SRC_RES));
  end
  // Outputs; push/vector activity is masked while the pad reset request is high
  always_comb begin
    STEP        = step;
    SEQ_BUSY    = step != IDLE;
    DORES       = res_pend | (src == SRC_RES & SEQ_BUSY);
    PUSH_EN     = ~RESP & (step == PUSH_PCH || step == PUSH_PCL || step == PUSH_P);
    WR_SUPPRESS = PUSH_EN & src == SRC_RES;
    B_OUT       = ~RESP & step == PUSH_P & src == SRC_BRK;
    VEC_EN      = ~RESP & (step == VEC_LO || step == VEC_HI);
    VADDR       = VEC_EN ? {src != SRC_NMI, src != SRC_RES, step == VEC_HI} : 3'b000;
    SET_I       = ~RESP & step == VEC_LO & ~vlo_seen;
  end
endmodule

// File: tb/tb_interrupt_seq.sv
// tb_interrupt_seq: directed and random stimulus checked against a vector-address level model
module tb_interrupt_seq;
  logic       PHI0 = 1'b0;
  logic       RES, n_NMIP, n_IRQP, RESP, n_PRDY, I_FLAG, FETCH, BRK_OP;
  logic [2:0] STEP, VADDR;
  logic       DORES, PUSH_EN, WR_SUPPRESS, B_OUT, VEC_EN, SET_I, SEQ_BUSY;
  int         n_checks = 0;
  int         n_errors = 0;
  // Model: phase 0 idle, 1 dummy, 2..4 pushes, 5..6 vector bytes; source kept as its vector address
  int          m_phase;
  logic [15:0] m_vec;
  bit          m_brk, m_res_pend, m_nmi_pend, m_prev, m_seti_given;

  interrupt_seq dut (
    .PHI0(PHI0), .RES(RES), .n_NMIP(n_NMIP), .n_IRQP(n_IRQP), .RESP(RESP), .n_PRDY(n_PRDY),
    .I_FLAG(I_FLAG), .FETCH(FETCH), .BRK_OP(BRK_OP), .STEP(STEP), .DORES(DORES), .PUSH_EN(PUSH_EN),
    .WR_SUPPRESS(WR_SUPPRESS), .B_OUT(B_OUT), .VADDR(VADDR), .VEC_EN(VEC_EN), .SET_I(SET_I),
    .SEQ_BUSY(SEQ_BUSY)
  );

  always #5 PHI0 = ~PHI0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = 0;
    m_vec = 16'hFFFC;
    m_brk = 0;
    m_res_pend = 1;
    m_nmi_pend = 0;
    m_prev = 0;
    m_seti_given = 0;
  endtask

  task automatic m_clock();
    bit nmi_fell, irq, np, rp, brk;
    int nxt;
    logic [15:0] vec;
    nmi_fell = !n_NMIP && !m_prev;
    irq = !n_IRQP && !I_FLAG;
    np = m_nmi_pend;
    rp = m_res_pend;
    vec = m_vec;
    brk = m_brk;
    nxt = m_phase;
    if (!RESP && !n_PRDY && m_phase == 5 && m_vec == 16'hFFFA) np = 0;
    if (nmi_fell) np = 1;
    if (!RESP && !n_PRDY && m_phase == 6 && m_vec == 16'hFFFC) rp = 0;
    if (RESP) rp = 1;
    if (RESP) nxt = 0;
    else if (m_phase == 0) begin
      if (!n_PRDY && (m_res_pend || (FETCH && (m_nmi_pend || irq || BRK_OP)))) begin
        nxt = 1;
        vec = m_res_pend ? 16'hFFFC : m_nmi_pend ? 16'hFFFA : 16'hFFFE;
        brk = !m_res_pend && !m_nmi_pend && !irq;
      end
    end else if (n_PRDY && (m_phase == 1 || m_phase >= 5)) nxt = m_phase;
    else begin
      nxt = (m_phase + 1) % 7;
      if (m_phase == 4 && m_vec == 16'hFFFE && m_nmi_pend) vec = 16'hFFFA;
    end
    m_seti_given = m_phase == 5;
    m_prev = !n_NMIP;
    m_nmi_pend = np;
    m_res_pend = rp;
    m_vec = vec;
    m_brk = brk;
    m_phase = nxt;
  endtask

  task automatic compare_all();
    bit push, ven;
    logic [15:0] va;
    push = !RESP && m_phase >= 2 && m_phase <= 4;
    ven = !RESP && m_phase >= 5;
    va = m_vec + 16'(m_phase == 6);
    check("step", 16'(STEP), 16'(m_phase));
    check("busy", 16'(SEQ_BUSY), 16'(m_phase != 0));
    check("dores", 16'(DORES), 16'(m_res_pend || (m_vec == 16'hFFFC && m_phase != 0)));
    check("push_en", 16'(PUSH_EN), 16'(push));
    check("wr_suppress", 16'(WR_SUPPRESS), 16'(push && m_vec == 16'hFFFC));
    check("b_out", 16'(B_OUT), 16'(!RESP && m_phase == 4 && m_brk));
    check("vec_en", 16'(VEC_EN), 16'(ven));
    check("vaddr", 16'(VADDR), ven ? 16'(va[2:0]) : 16'h0);
    check("set_i", 16'(SET_I), 16'(!RESP && m_phase == 5 && !m_seti_given));
  endtask

  // One clock: compare mid-cycle, advance the model on the edge, return just after it
  task automatic tick();
    @(negedge PHI0);
    if (RES) m_reset();
    compare_all();
    @(posedge PHI0);
    if (RES) m_reset();
    else m_clock();
    #1;
  endtask

  initial begin
    RES = 1; n_NMIP = 1; n_IRQP = 1; RESP = 0; n_PRDY = 0; I_FLAG = 1; FETCH = 0; BRK_OP = 0;
    m_reset();
    tick();
    check("rst_dores", 16'(DORES), 16'h1);
    check("rst_step", 16'(STEP), 16'h0);
    check("rst_vaddr", 16'(VADDR), 16'h0);
    // reset sequence right after RES falls
    RES = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("res_seq_step", 16'(STEP), 16'(i));
      if (i >= 2 && i <= 4) check("res_seq_wrsup", 16'(WR_SUPPRESS), 16'h1);
      if (i == 5) check("res_vlo", 16'(VADDR), 16'h4);
      if (i == 6) check("res_vhi", 16'(VADDR), 16'h5);
    end
    tick();
    check("res_done_dores", 16'(DORES), 16'h0);
    check("res_done_step", 16'(STEP), 16'h0);
    // NMI edge then fetch; held-low pad must not retrigger
    n_NMIP = 0;
    tick();
    FETCH = 1;
    tick();
    check("nmi_start", 16'(STEP), 16'h1);
    for (int i = 2; i <= 6; i++) begin
      tick();
      if (i == 5) check("nmi_vlo", 16'(VADDR), 16'h2);
      if (i == 5) check("nmi_seti", 16'(SET_I), 16'h1);
      if (i == 6) check("nmi_vhi", 16'(VADDR), 16'h3);
      if (i == 4) check("nmi_b", 16'(B_OUT), 16'h0);
    end
    tick();
    repeat (3) begin
      tick();
      check("nmi_no_retrig", 16'(STEP), 16'h0);
    end
    n_NMIP = 1;
    tick();
    n_NMIP = 0;
    tick();
    tick();
    check("nmi_second", 16'(STEP), 16'h1);
    FETCH = 0;
    repeat (6) tick();
    // BRK hijacked by NMI arriving in PUSH_PCL
    n_NMIP = 1;
    FETCH = 1; BRK_OP = 1;
    tick();
    FETCH = 0; BRK_OP = 0;
    tick();
    tick();
    check("brk_pcl", 16'(STEP), 16'h3);
    n_NMIP = 0;
    tick();
    check("brk_b", 16'(B_OUT), 16'h1);
    tick();
    check("brk_hijack_vlo", 16'(VADDR), 16'h2);
    tick();
    check("brk_hijack_vhi", 16'(VADDR), 16'h3);
    tick();
    n_NMIP = 1;
    // IRQ masked then unmasked
    n_IRQP = 0; I_FLAG = 1; FETCH = 1;
    repeat (3) begin
      tick();
      check("irq_masked", 16'(STEP), 16'h0);
    end
    I_FLAG = 0;
    tick();
    check("irq_start", 16'(STEP), 16'h1);
    FETCH = 0; n_IRQP = 1;
    repeat (4) tick();
    check("irq_vlo", 16'(VADDR), 16'h6);
    tick();
    check("irq_vhi", 16'(VADDR), 16'h7);
    tick();
    // stalls: ignored in pushes, honoured in VEC_LO with a single SET_I
    n_IRQP = 0; FETCH = 1;
    tick();
    FETCH = 0; n_IRQP = 1;
    tick();
    n_PRDY = 1;
    tick();
    check("stall_pcl_adv", 16'(STEP), 16'h3);
    tick();
    check("stall_p_adv", 16'(STEP), 16'h4);
    n_PRDY = 0;
    tick();
    check("stall_vlo_seti", 16'(SET_I), 16'h1);
    n_PRDY = 1;
    repeat (3) begin
      tick();
      check("stall_vlo_hold", 16'(STEP), 16'h5);
      check("stall_vlo_seti_once", 16'(SET_I), 16'h0);
    end
    n_PRDY = 0;
    tick();
    tick();
    // RESP mid-sequence aborts, then a full reset sequence follows
    n_IRQP = 0; FETCH = 1;
    tick();
    FETCH = 0; n_IRQP = 1;
    tick();
    tick();
    RESP = 1;
    tick();
    check("resp_abort_step", 16'(STEP), 16'h0);
    check("resp_abort_dores", 16'(DORES), 16'h1);
    RESP = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("resp_seq_step", 16'(STEP), 16'(i));
    end
    tick();
    check("resp_done_dores", 16'(DORES), 16'h0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      RES    = $urandom_range(0, 599) == 0;
      RESP   = $urandom_range(0, 79) == 0;
      n_PRDY = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 11) == 0) n_NMIP = ~n_NMIP;
      n_IRQP = $urandom_range(0, 7) != 0;
      I_FLAG = $urandom_range(0, 1) == 0;
      FETCH  = $urandom_range(0, 1) == 0;
      BRK_OP = $urandom_range(0, 15) == 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
